// File: rtl/rotate_cmd_queue.sv
// rotate_cmd_queue
//   Command buffer in front of a combinational N-bit rotator. Rotate
//   requests (data, shift) from a bursty producer are held in a small
//   first-word-fall-through FIFO. Each shift amount is reduced modulo N
//   as it is written, so the rotator only ever sees a legal shift.
//
// Parameters
//   N      data width, must match the downstream rotator
//   DEPTH  number of FIFO entries, power of two, >= 2
//   SW     shift field width, derived from N ($clog2(N)+1), do not override
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset, clears queue and storage
//   flush      synchronous clear of all queued entries, beats push/pop
//   in_data    data word to rotate
//   in_shift   requested rotate amount, any value 0..2^SW-1
//   in_valid   producer has a request
//   in_ready   queue can accept a request (count < DEPTH)
//   out_data   head-entry data
//   out_shift  head-entry shift, always < N
//   out_valid  head entry is valid (queue not empty)
//   out_ready  consumer takes the head entry
//   count      number of stored entries, 0..DEPTH
//   full       count == DEPTH
//   empty      count == 0
module rotate_cmd_queue #(
  parameter int N     = 4,
  parameter int DEPTH = 4,
  parameter int SW    = $clog2(N) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic [N-1:0]           in_data,
  input  logic [SW-1:0]          in_shift,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [N-1:0]           out_data,
  output logic [SW-1:0]          out_shift,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [SW-1:0] N_SW    = SW'(N);
  localparam logic [SW-1:0] N_MASK  = SW'(N - 1);
  localparam bit            N_POW2  = ((N & (N - 1)) == 0);
  // Worst case number of subtractions to bring 2^SW-1 below N.
  localparam int            NSUB    = ((1 << SW) + N - 1) / N - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [N-1:0]  data_mem_q  [DEPTH];
  logic [SW-1:0] shift_mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic          push;
  logic          pop;
  logic [SW-1:0] norm_shift;

  // Status is taken from registered count only; a pop in the same cycle
  // does not open the input side until the following cycle.
  assign full      = (count_q == DEPTH_C);
  assign empty     = (count_q == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign count     = count_q;

  assign push = in_valid & in_ready;
  assign pop  = out_valid & out_ready;

  assign out_data  = data_mem_q[rd_ptr_q];
  assign out_shift = shift_mem_q[rd_ptr_q];

  // Shift normalisation: plain mask when N is a power of two, otherwise
  // an unrolled chain of conditional subtracts.
  always_comb begin
    norm_shift = in_shift;
    if (N_POW2) begin
      norm_shift = in_shift & N_MASK;
    end else begin
      for (int unsigned i = 0; i < NSUB; i++) begin
        if (norm_shift >= N_SW) begin
          norm_shift = norm_shift - N_SW;
        end
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_mem_q[i]  <= '0;
        shift_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      // Flush leaves storage untouched; only the pointers are cleared.
      if (push && !flush) begin
        data_mem_q[wr_ptr_q]  <= in_data;
        shift_mem_q[wr_ptr_q] <= norm_shift;
      end
    end
  end

endmodule

// File: tb/tb_rotate_cmd_queue.sv
module tb_rotate_cmd_queue;

  localparam int N     = 4;
  localparam int DEPTH = 4;
  localparam int SW    = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic [N-1:0]  in_data = '0;
  logic [SW-1:0] in_shift = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [N-1:0]  out_data;
  logic [SW-1:0] out_shift;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [2:0]    count;
  logic          full;
  logic          empty;

  // Second instance with a non-power-of-two width.
  logic          flush5 = 1'b0;
  logic [4:0]    in_data5 = '0;
  logic [3:0]    in_shift5 = '0;
  logic          in_valid5 = 1'b0;
  logic          in_ready5;
  logic [4:0]    out_data5;
  logic [3:0]    out_shift5;
  logic          out_valid5;
  logic          out_ready5 = 1'b0;
  logic [2:0]    count5;
  logic          full5;
  logic          empty5;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] d;
    int           s;
  } ent_t;

  ent_t exp_q[$];

  always #5 clk = ~clk;

  rotate_cmd_queue #(.N(N), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_shift(in_shift), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_shift(out_shift), .out_valid(out_valid), .out_ready(out_ready),
    .count(count), .full(full), .empty(empty)
  );

  rotate_cmd_queue #(.N(5), .DEPTH(4)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush5),
    .in_data(in_data5), .in_shift(in_shift5), .in_valid(in_valid5), .in_ready(in_ready5),
    .out_data(out_data5), .out_shift(out_shift5), .out_valid(out_valid5), .out_ready(out_ready5),
    .count(count5), .full(full5), .empty(empty5)
  );

  // One clock of the reference queue: decide push/pop from the current
  // inputs and queue occupancy, then apply them at the rising edge.
  task automatic step();
    bit do_push;
    bit do_pop;
    do_push = in_valid && (exp_q.size() < DEPTH);
    do_pop  = out_ready && (exp_q.size() > 0);
    @(posedge clk);
    if (flush) begin
      exp_q.delete();
    end else begin
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back('{d: in_data, s: int'(in_shift) % N});
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    flush     = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    @(negedge clk);
    total++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_status: count=%0d empty=%b full=%b in_ready=%b out_valid=%b, want 0 1 0 1 0",
               count, empty, full, in_ready, out_valid);
    end
    total++;
    if (out_data !== 4'h0 || out_shift !== 3'd0) begin
      bad++;
      $display("FAIL reset_head: out_data=%h out_shift=%0d, want 0 0", out_data, out_shift);
    end
  endtask

  task automatic test_fill_drain();
    logic [N-1:0] dv [4];
    dv[0] = 4'hA; dv[1] = 4'h3; dv[2] = 4'h9; dv[3] = 4'h6;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = dv[i];
      in_shift = SW'(i);
      step();
    end
    in_valid = 1'b0;
    total++;
    if (full !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      bad++;
      $display("FAIL fill_full: full=%b in_ready=%b count=%0d, want 1 0 4", full, in_ready, count);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_data !== dv[i] || int'(out_shift) != i) begin
        bad++;
        $display("FAIL drain_%0d: valid=%b data=%h shift=%0d, want 1 %h %0d",
                 i, out_valid, out_data, out_shift, dv[i], i);
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1 || out_valid !== 1'b0 || count !== 3'd0) begin
      bad++;
      $display("FAIL drain_empty: empty=%b out_valid=%b count=%0d, want 1 0 0", empty, out_valid, count);
    end
  endtask

  task automatic test_norm();
    int sv [4];
    int ev [4];
    sv[0] = 5; sv[1] = 6; sv[2] = 7; sv[3] = 4;
    ev[0] = 1; ev[1] = 2; ev[2] = 3; ev[3] = 0;
    idle_inputs();
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = N'($urandom);
      in_shift = SW'(sv[i]);
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (int'(out_shift) != ev[i] || out_data !== exp_q[0].d) begin
        bad++;
        $display("FAIL norm4_%0d: shift=%0d data=%h, want %0d %h", i, out_shift, out_data, ev[i], exp_q[0].d);
      end
      step();
    end
    out_ready = 1'b0;
    // N=5: every request value 0..15 must come out as value mod 5.
    for (int s = 15; s >= 0; s--) begin
      in_valid5 = 1'b1;
      in_shift5 = 4'(s);
      in_data5  = 5'(s);
      @(posedge clk);
      @(negedge clk);
      in_valid5 = 1'b0;
      total++;
      if (out_valid5 !== 1'b1 || int'(out_shift5) != s % 5 || int'(out_data5) != s) begin
        bad++;
        $display("FAIL norm5_%0d: valid=%b shift=%0d data=%0d, want 1 %0d %0d",
                 s, out_valid5, out_shift5, out_data5, s % 5, s);
      end
      out_ready5 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready5 = 1'b0;
    end
  endtask

  task automatic test_simultaneous();
    idle_inputs();
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(4'h1 + i);
      in_shift = SW'(i);
      step();
    end
    in_valid  = 1'b1;
    in_data   = 4'hC;
    in_shift  = 3'd6;
    out_ready = 1'b1;
    step();
    idle_inputs();
    total++;
    if (count !== 3'd2 || out_data !== 4'h2) begin
      bad++;
      $display("FAIL pushpop_count: count=%0d head=%h, want 2 2", count, out_data);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (out_data !== 4'hC || out_shift !== 3'd2) begin
      bad++;
      $display("FAIL pushpop_order: head=%h shift=%0d, want c 2", out_data, out_shift);
    end
    step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 4'(4'h8 + i);
      in_shift = 3'(i + 1);
      step();
    end
    in_data   = 4'hF;
    out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready_before: in_ready=%b, want 0", in_ready);
    end
    step();
    idle_inputs();
    total++;
    if (count !== 3'd3 || in_ready !== 1'b1 || full !== 1'b0) begin
      bad++;
      $display("FAIL full_pushpop: count=%0d in_ready=%b full=%b, want 3 1 0", count, in_ready, full);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total++;
      if (out_data !== 4'(4'h8 + i)) begin
        bad++;
        $display("FAIL full_refused_%0d: data=%h, want %h", i, out_data, 4'(4'h8 + i));
      end
      step();
    end
    out_ready = 1'b0;
    total++;
    if (empty !== 1'b1) begin
      bad++;
      $display("FAIL full_drain_empty: empty=%b, want 1", empty);
    end
  endtask

  task automatic test_flush_wrap();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(i); in_shift = 3'(i); step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) step();
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = 4'(4'h4 + i); in_shift = 3'(7 - i); step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_data !== 4'(4'h4 + i) || int'(out_shift) != (7 - i) % 4) begin
        bad++;
        $display("FAIL wrap_%0d: data=%h shift=%0d, want %h %0d", i, out_data, out_shift, 4'(4'h4 + i), (7 - i) % 4);
      end
      step();
    end
    flush = 1'b1; in_valid = 1'b1; in_data = 4'hE; out_ready = 1'b1;
    step();
    idle_inputs();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || empty !== 1'b1) begin
      bad++;
      $display("FAIL flush: count=%0d out_valid=%b empty=%b, want 0 0 1", count, out_valid, empty);
    end
    in_valid = 1'b1; in_data = 4'h7; in_shift = 3'd5;
    step();
    in_valid = 1'b0;
    total++;
    if (count !== 3'd1 || out_data !== 4'h7 || out_shift !== 3'd1) begin
      bad++;
      $display("FAIL after_flush: count=%0d data=%h shift=%0d, want 1 7 1", count, out_data, out_shift);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 4'(4'h9 + i); in_shift = 3'(i); step();
    end
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    exp_q.delete();
    total++;
    if (count !== 3'd0 || out_valid !== 1'b0 || out_data !== 4'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: count=%0d out_valid=%b data=%h in_ready=%b, want 0 0 0 1",
               count, out_valid, out_data, in_ready);
    end
    #1 rst_n = 1'b1;
    @(negedge clk);
    in_valid = 1'b1; in_data = 4'h5; in_shift = 3'd3;
    step();
    in_valid = 1'b0;
    total++;
    if (out_valid !== 1'b1 || out_data !== 4'h5 || out_shift !== 3'd3) begin
      bad++;
      $display("FAIL reset_mid_push: valid=%b data=%h shift=%0d, want 1 5 3", out_valid, out_data, out_shift);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_random();
    idle_inputs();
    for (int c = 0; c < 400; c++) begin
      if (!(in_valid && !in_ready)) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_data  = N'($urandom);
        in_shift = SW'($urandom);
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      step();
      total++;
      if (int'(count) != exp_q.size() || out_valid !== (exp_q.size() > 0) ||
          full !== (exp_q.size() == DEPTH) || empty !== (exp_q.size() == 0) ||
          in_ready !== (exp_q.size() < DEPTH)) begin
        bad++;
        $display("FAIL rand_status_%0d: count=%0d valid=%b full=%b empty=%b ready=%b, want count=%0d",
                 c, count, out_valid, full, empty, in_ready, exp_q.size());
      end
      if (exp_q.size() > 0) begin
        total++;
        if (out_data !== exp_q[0].d || int'(out_shift) != exp_q[0].s) begin
          bad++;
          $display("FAIL rand_head_%0d: data=%h shift=%0d, want %h %0d",
                   c, out_data, out_shift, exp_q[0].d, exp_q[0].s);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_norm();
    test_simultaneous();
    test_flush_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rotate_cmd_queue.md
Name: rotate_cmd_queue

Overview:
- Upstream command stage for barrelShifterNBit.
- Buffers (data, shift) rotate requests from a producer in a small first-word-fall-through FIFO.
- Normalises each shift amount to the range 0..N-1 at push time.
- Presents the head entry to the combinational rotator under a valid/ready handshake, so bursty producers do not stall and the rotator always sees a legal shift.

Parameters:
- N, 4, data width; must match the downstream rotator's n.
- DEPTH, 4, number of FIFO entries; must be a power of two, >= 2.
- SW, $clog2(N)+1, shift field width; derived, do not override.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of all queued entries
- in_data  input  N  data word to rotate
- in_shift  input  SW  requested rotate amount; any value 0..2^SW-1 is legal
- in_valid  input  1  producer has a request
- in_ready  output  1  queue can accept a request
- out_data  output  N  head-entry data; drives the rotator's in
- out_shift  output  SW  head-entry normalised shift, always < N; drives the rotator's shift
- out_valid  output  1  head entry is valid
- out_ready  input  1  consumer takes the head entry
- count  output  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- full  output  1  count == DEPTH
- empty  output  1  count == 0

Behaviour:
- One clock domain.
- Async reset (rst_n low) sets the following; all other outputs follow from these values:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - all storage entries = 0
  - out_valid = 0, out_data = 0, out_shift = 0
  - in_ready = 1, full = 0, empty = 1
- Reset release takes effect on the next rising edge.
- in_ready = (count < DEPTH). It is purely registered-state derived and does not look at same-cycle pop.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- On push, the queue stores in_data and norm(in_shift) at wr_ptr, then wr_ptr = wr_ptr + 1 mod DEPTH.
- norm(s) = s mod N, for any N:
  - N power of two: mask to the low $clog2(N) bits.
  - Otherwise: conditional subtract of N repeated until < N. This is combinational; at most ceil(2^SW/N)-1 subtractions.
  - Zero-extend the result to SW bits.
- On pop, rd_ptr = rd_ptr + 1 mod DEPTH.
- out_data and out_shift always show the entry at rd_ptr. out_valid = ~empty.
- Latency: a push into an empty queue gives out_valid = 1 on the next cycle. There is no same-cycle bypass.
- count update:
  - +1 on push only, -1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal whenever 0 < count < DEPTH.
- When full, push is refused even if pop occurs in the same cycle. in_ready rises the cycle after the pop.
- When empty, out_ready is ignored and no pop occurs.
- flush (synchronous):
  - Clears wr_ptr, rd_ptr and count on the edge.
  - Has priority over push and pop in the same cycle; both are discarded.
  - Storage contents are not cleared, but out_valid = 0.
- Producer contract: in_data and in_shift must be held while in_valid & ~in_ready. The block does not check this.
- Consumer contract: out_data and out_shift are stable while out_valid & ~out_ready.
- Pointer wrap-around is by natural binary overflow of $clog2(DEPTH)-bit pointers. count alone decides full and empty.
- Reset asserted mid-operation discards all entries immediately (async). No output glitches to an X state.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles, then release -> count = 0, empty = 1, full = 0, in_ready = 1, out_valid = 0, out_data = 0, out_shift = 0.
- Fill and drain: N=4. Push (4'hA,0), (4'h3,1), (4'h9,2), (4'h6,3) with out_ready = 0 -> full = 1, in_ready = 0, count = 4. Then set out_ready = 1 -> four pops in FIFO order with out_shift 0,1,2,3; empty = 1 after the 4th.
- Normalisation: N=4, push in_shift = 5, 6, 7, 4 -> out_shift = 1, 2, 3, 0. With N=5 (SW=4), push 13 -> out_shift = 3.
- Simultaneous events:
  - count = 2, push and pop in the same cycle -> count stays 2 and order is preserved.
  - count = 4, in_valid = 1 and out_ready = 1 -> only the pop occurs, count = 3, in_ready = 1 on the next cycle.
- Flush and wrap: push 3, pop 3, push 4 (pointers wrap) -> data is correct in order. Then assert flush together with in_valid and out_ready -> count = 0, out_valid = 0 next cycle, nothing stored.
- Reset mid-operation: with count = 3, pulse rst_n low between clock edges -> count = 0 and out_valid = 0 immediately, no clock needed. After release, a push appears at the head 1 cycle later.
